pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register, the generalised successor to the fixed per-stage FD/DE/EM/MW registers. It carries an arbitrary payload split into a control field and a data field between any two pipeline stages, using a valid/ready handshake instead of a bare write enable. It supports synchronous flush for bubble insertion and an optional two-entry skid buffer that breaks the combinational ready path. A saturating stall counter is included for performance monitoring.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/stall_counter.sv | 33 +++
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared skid-state encoding and per-stage default widths
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int FD_DATA_W = 64;
  localparam int DE_DATA_W = 128;
  localparam int EM_DATA_W = 96;
  localparam int MW_DATA_W = 64;

  localparam int FD_CTRL_W = 1;
  localparam int DE_CTRL_W = 8;
  localparam int EM_CTRL_W = 4;
  localparam int MW_CTRL_W = 2;

  function automatic logic skid_full(input skid_state_e s);
    return s == TWO;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - saturating event counter with synchronous clear
module stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline stage with optional skid buffer
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic in_ready_core;

  // Ready is forced high while reset is held so upstream never sees a stall from reset.
  assign in_ready = in_ready_core | ~reset_n;

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e       state_q, state_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
      logic              ready_q;
      logic              in_xfer, out_xfer;

      assign in_xfer  = in_valid && ready_q;
      assign out_xfer = (state_q != EMPTY) && out_ready;

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY:   if (in_xfer) state_d = ONE;
            ONE: begin
              if (in_xfer && !out_xfer)      state_d = TWO;
              else if (out_xfer && !in_xfer) state_d = EMPTY;
            end
            TWO:     if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
          endcase
        end
      end

      always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end else begin
          case (state_q)
            EMPTY: if (in_xfer) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end
            ONE: begin
              if (in_xfer && !out_xfer) begin
                skid_ctrl_d = in_ctrl;
                skid_data_d = in_data;
              end else if (out_xfer && !in_xfer) begin
                main_ctrl_d = '0;
              end else if (in_xfer && out_xfer) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
              end
            end
            TWO: if (out_xfer) begin
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              skid_ctrl_d = '0;
            end
            default: begin
              main_ctrl_d = '0;
              skid_ctrl_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          state_q     <= EMPTY;
          ready_q     <= 1'b1;
          main_ctrl_q <= '0;
          main_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          ready_q     <= !skid_full(state_d);
          main_ctrl_q <= main_ctrl_d;
          main_data_q <= main_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end

      always_comb begin
        out_valid     = (state_q != EMPTY);
        out_ctrl      = main_ctrl_q;
        out_data      = main_data_q;
        in_ready_core = ready_q;
      end
    end else begin : g_single
      logic              valid_q, valid_d;
      logic [CTRL_W-1:0] ctrl_q, ctrl_d;
      logic [DATA_W-1:0] data_q, data_d;
      logic              in_xfer, out_xfer;

      assign in_ready_core = !valid_q || out_ready;
      assign in_xfer       = in_valid && in_ready_core;
      assign out_xfer      = valid_q && out_ready;

      always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end else if (in_xfer) begin
          valid_d = 1'b1;
          ctrl_d  = in_ctrl;
          data_d  = in_data;
        end else if (out_xfer) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          valid_q <= 1'b0;
          ctrl_q  <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          ctrl_q  <= ctrl_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q;
      assign out_ctrl  = ctrl_q;
      assign out_data  = data_q;
    end
  endgenerate

  stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .inc_i  (out_valid && !out_ready),
    .clr_i  (stall_clr),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg in both skid modes
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, out_ready, flush, stall_clr;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        ir_a, ov_a, ir_b, ov_b;
  logic [7:0]  oc_a, oc_b;
  logic [31:0] od_a, od_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_ctrl(oc_a), .out_data(od_a), .flush(flush), .stall_cnt(cnt_a),
    .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_ctrl(oc_b), .out_data(od_b), .flush(flush), .stall_cnt(cnt_b),
    .stall_clr(stall_clr)
  );

  int checks = 0;
  int errors = 0;

  // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (single register).
  int          n_m[2];
  logic [31:0] qd[2][2];
  logic [7:0]  qc[2][2];
  logic [31:0] last_m[2];
  int          cnt_m[2];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ov_e;
    logic [31:0] od_e;
    logic        ir_e;
    int          cnt_e;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int cmax(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  function automatic logic exp_ir(input int k);
    if (!reset_n) return 1'b1;
    if (k == 0) return n_m[0] < 2;
    return (n_m[1] == 0) || out_ready;
  endfunction

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic        e_ov;
      logic [7:0]  e_oc;
      logic [31:0] e_od;
      e_ov = n_m[k] > 0;
      e_oc = e_ov ? qc[k][0] : 8'h00;
      e_od = e_ov ? qd[k][0] : last_m[k];
      chk($sformatf("dut%0d out_valid", k), (k == 0) ? ov_a : ov_b, e_ov);
      chk($sformatf("dut%0d out_ctrl", k), (k == 0) ? oc_a : oc_b, e_oc);
      chk($sformatf("dut%0d out_data", k), (k == 0) ? od_a : od_b, e_od);
      chk($sformatf("dut%0d in_ready", k), (k == 0) ? ir_a : ir_b, exp_ir(k));
      chk($sformatf("dut%0d stall_cnt", k), (k == 0) ? {28'd0, cnt_a} : {16'd0, cnt_b}, cnt_m[k]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic ov, ixf, oxf;
      ov  = n_m[k] > 0;
      ixf = in_valid && exp_ir(k);
      oxf = ov && out_ready;
      if (!reset_n) begin
        n_m[k] = 0; last_m[k] = 0; cnt_m[k] = 0;
      end else begin
        if (stall_clr) cnt_m[k] = 0;
        else if (ov && !out_ready && cnt_m[k] < cmax(k)) cnt_m[k]++;
        if (flush) begin
          n_m[k] = 0;
        end else begin
          if (oxf) begin
            qd[k][0] = qd[k][1]; qc[k][0] = qc[k][1]; n_m[k]--;
          end
          if (ixf) begin
            qd[k][n_m[k]] = in_data; qc[k][n_m[k]] = in_ctrl; n_m[k]++;
          end
          if (n_m[k] > 0) last_m[k] = qd[k][0];
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl, input logic clr);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; stall_clr = clr;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_m[k] = 0; last_m[k] = 0; cnt_m[k] = 0;
      qd[k][0] = 0; qd[k][1] = 0; qc[k][0] = 0; qc[k][1] = 0;
    end
    reset_n = 1'b0;
    drive(1'b1, 32'hDEAD, 8'h5A, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst in_ready_a", ir_a, 1'b1);
    chk("rst in_ready_b", ir_b, 1'b1);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst out_valid", ov_a, 1'b0);
    chk("rst out_ctrl", oc_a, 8'h00);
    chk("rst out_data", od_a, 32'h0);
    chk("rst stall_cnt", cnt_a, 4'd0);
    chk("rst in_ready", ir_a, 1'b1);

    // Backpressure: A,B stored, C held upstream, released in order.
    tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 32'h0, 1'b1, 0};
    tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 1'b1, 0};
    tbl[2] = '{1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 1};
    tbl[3] = '{1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 2};
    tbl[4] = '{1'b1, 32'hC, 1'b1, 1'b1, 32'hA, 1'b0, 3};
    tbl[5] = '{1'b1, 32'hC, 1'b1, 1'b1, 32'hB, 1'b1, 3};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 3};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b1, 3};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].id, 8'h11, tbl[i].ordy, 1'b0, 1'b0);
      #1;
      chk($sformatf("tbl%0d out_valid", i), ov_a, tbl[i].ov_e);
      chk($sformatf("tbl%0d out_data", i), od_a, tbl[i].od_e);
      chk($sformatf("tbl%0d in_ready", i), ir_a, tbl[i].ir_e);
      chk($sformatf("tbl%0d stall_cnt", i), cnt_a, tbl[i].cnt_e);
      step();
    end

    // Streaming 1..8 with out_ready high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
      step();
      chk($sformatf("stream%0d out_data", i), od_a, i);
      chk($sformatf("stream%0d in_ready", i), ir_a, 1'b1);
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    step();

    // Flush while TWO, with an incoming beat D.
    drive(1'b1, 32'h1111, 8'hFF, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2222, 8'hFF, 1'b0, 1'b0, 1'b0); step();
    chk("flush pre in_ready", ir_a, 1'b0);
    drive(1'b1, 32'hD0D0, 8'hFF, 1'b0, 1'b1, 1'b0); step();
    chk("flush out_valid", ov_a, 1'b0);
    chk("flush out_ctrl", oc_a, 8'h00);
    chk("flush in_ready", ir_a, 1'b1);
    chk("flush data hold", od_a, 32'h1111);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0); step();
      chk("flush D absent", ov_a, 1'b0);
    end

    // SKID=0 replace-in-place with no bubble.
    drive(1'b1, 32'hAAAA0001, 8'h31, 1'b1, 1'b0, 1'b0); step();
    chk("simul first", od_b, 32'hAAAA0001);
    drive(1'b1, 32'hAAAA0002, 8'h32, 1'b1, 1'b0, 1'b0); step();
    chk("simul valid", ov_b, 1'b1);
    chk("simul replace", od_b, 32'hAAAA0002);
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0); step();

    // Saturation of a 4-bit stall counter, then clear while still stalled.
    drive(1'b1, 32'h5A5A, 8'h01, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat stall_cnt", cnt_a, 4'd15);
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1); step();
    chk("clr stall_cnt", cnt_a, 4'd0);
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0); step();
    chk("post clr stall_cnt", cnt_a, 4'd1);

    // Reset while TWO.
    drive(1'b1, 32'h7777, 8'hFF, 1'b0, 1'b0, 1'b0); step();
    chk("pre reset in_ready", ir_a, 1'b0);
    reset_n = 1'b0;
    drive(1'b1, 32'h8888, 8'hFF, 1'b0, 1'b0, 1'b0); step();
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst out_valid", ov_a, 1'b0);
    chk("midrst out_ctrl", oc_a, 8'h00);
    chk("midrst out_data", od_a, 32'h0);
    chk("midrst stall_cnt", cnt_a, 4'd0);
    chk("midrst in_ready", ir_a, 1'b1);
    drive(1'b1, 32'h9999, 8'h42, 1'b1, 1'b0, 1'b0); step();
    chk("postrst out_data", od_a, 32'h9999);
    chk("postrst out_ctrl", oc_a, 8'h42);

    // Random traffic against the reference queues.
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 96) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 22) == 0,
            $urandom_range(0, 28) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
